ysyx_25040111_axi_mem_slave: RTL and testbench

AXI4-subset responder (slave) modelling word-addressed memory. It is the far end of the load/store unit's master port, for simulation runs without the SoC. Write and read channels are independent. Reads support single beats and FIXED/INCR bursts; writes are single-beat with byte strobes. Read latency is programmable, and out-of-range addresses return error responses.

---
 rtl/ysyx_25040111_axi_mem_slave.sv | 258 +++++++++++++++++++++++++
 tb/tb_ysyx_25040111_axi_mem_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4-subset memory responder: word-addressed RAM behind independent read and write channels.
// Single-beat strobed writes; single/FIXED/INCR read bursts with programmable first-beat latency.
module ysyx_25040111_axi_mem_slave #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) < DEPTH;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return IDX_W'(off);
  endfunction

  // Write channel
  w_state_t    w_state;
  logic        aw_got, w_got;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        wlast_q;

  logic        aw_hs_c, w_hs_c, commit_c, we_c, wl_c;
  logic [31:0] wa_c, wd_c;
  logic [3:0]  ws_c;
  logic [1:0]  wresp_c;

  // A handshake on this edge counts as captured, so pick live inputs until the flag is set.
  always_comb begin
    aw_hs_c  = awvalid & awready;
    w_hs_c   = wvalid & wready;
    wa_c     = aw_got ? awaddr_q : awaddr;
    wd_c     = w_got ? wdata_q : wdata;
    ws_c     = w_got ? wstrb_q : wstrb;
    wl_c     = w_got ? wlast_q : wlast;
    commit_c = (w_state == W_IDLE) & (aw_got | aw_hs_c) & (w_got | w_hs_c);
    if (!in_range(wa_c))  wresp_c = RESP_DECERR;
    else if (!wl_c)       wresp_c = RESP_SLVERR;
    else                  wresp_c = RESP_OKAY;
    we_c     = commit_c & (wresp_c == RESP_OKAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit_c) begin
            w_state <= W_RESP;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wresp_c;
          end else begin
            if (aw_hs_c) begin
              aw_got   <= 1'b1;
              awready  <= 1'b0;
              awaddr_q <= awaddr;
            end
            if (w_hs_c) begin
              w_got   <= 1'b1;
              wready  <= 1'b0;
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              wlast_q <= wlast;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Memory array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (ws_c[i]) mem[word_idx(wa_c)][8*i +: 8] <= wd_c[8*i +: 8];
      end
    end
  end

  // Read channel
  r_state_t         r_state;
  logic [LAT_W-1:0] lat_cnt;
  logic [31:0]      raddr;
  logic [7:0]       rlen, rcnt;
  logic [2:0]       rsize;
  logic [1:0]       rburst;

  logic [31:0] b_addr_c, b_data_c;
  logic [7:0]  b_cnt_c, b_len_c;
  logic [2:0]  b_size_c;
  logic [1:0]  b_burst_c, b_resp_c;
  logic        b_last_c;

  // Describes the beat the read FSM would present after the coming edge.
  always_comb begin
    b_addr_c  = raddr;
    b_cnt_c   = rcnt;
    b_len_c   = rlen;
    b_size_c  = rsize;
    b_burst_c = rburst;
    case (r_state)
      R_IDLE: begin
        b_addr_c  = araddr;
        b_cnt_c   = '0;
        b_len_c   = arlen;
        b_size_c  = arsize;
        b_burst_c = arburst;
      end
      R_DATA: begin
        b_addr_c = (rburst == BURST_FIXED) ? raddr : raddr + 32'd4;
        b_cnt_c  = rcnt + 8'd1;
      end
      default: ;
    endcase
    if ((b_burst_c == BURST_WRAP) || (b_size_c > 3'd2)) b_resp_c = RESP_SLVERR;
    else if (!in_range(b_addr_c))                         b_resp_c = RESP_DECERR;
    else                                                  b_resp_c = RESP_OKAY;
    b_data_c = (b_resp_c == RESP_OKAY) ? mem[word_idx(b_addr_c)] : 32'd0;
    b_last_c = (b_cnt_c == b_len_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      lat_cnt <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      rsize   <= '0;
      rburst  <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            raddr   <= araddr;
            rlen    <= arlen;
            rsize   <= arsize;
            rburst  <= arburst;
            rcnt    <= '0;
            arready <= 1'b0;
            if (RD_LAT == 0) begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rdata   <= b_data_c;
              rresp   <= b_resp_c;
              rlast   <= b_last_c;
            end else begin
              r_state <= R_WAIT;
              lat_cnt <= LAT_W'(RD_LAT - 1);
            end
          end
        end
        R_WAIT: begin
          if (lat_cnt == '0) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= b_data_c;
            rresp   <= b_resp_c;
            rlast   <= b_last_c;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
            end else begin
              raddr <= b_addr_c;
              rcnt  <= b_cnt_c;
              rdata <= b_data_c;
              rresp <= b_resp_c;
              rlast <= b_last_c;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_mem_slave.sv
// Self-checking bench for the AXI memory responder: directed cases plus randomized traffic
// compared against a flat-array memory model.
module tb_ysyx_25040111_axi_mem_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  ysyx_25040111_axi_mem_slave #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          ref_wr  [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int k = 0;
    logic [1:0] exp;
    exp = !mapped(addr) ? 2'b11 : (!last ? 2'b10 : 2'b00);
    awaddr = addr; wdata = data; wstrb = strb; wlast = last; bready = 1'b0;
    while (!(aw_done && w_done) && k < 50) begin
      @(negedge clk);
      if (aw_done && !w_done) chk("awready_drop", 32'(awready), 0);
      if (w_done && !aw_done) chk("wready_drop", 32'(wready), 0);
      awvalid = !aw_done && (k >= aw_dly);
      wvalid  = !w_done && (k >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      k++;
    end
    chk("write_accepted", 32'(aw_done && w_done), 1);
    if (exp == 2'b00) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[widx(addr)][8*i +: 8] = data[8*i +: 8];
      if (strb == 4'hF) ref_wr[widx(addr)] = 1;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_first", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), 32'(exp));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("bresp_hold", 32'(bresp), 32'(exp));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 0);
    chk("awready_back", 32'(awready && wready), 1);
  endtask

  // mode: 0 always ready, 1 toggle per cycle, 2 random, 3 low for 4 cycles
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode);
    int cyc = 0;
    @(negedge clk);
    chk("arready_idle", 32'(arready), 1);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      chk("rvalid_latency", 32'(rvalid), 0);
      @(negedge clk);
    end
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] ea, ed;
      logic [1:0] er;
      bit done = 0;
      int tries = 0;
      ea = (burst == 2'b00) ? addr : addr + 32'(4 * b);
      er = (burst == 2'b10 || size > 3'd2) ? 2'b10 : (!mapped(ea) ? 2'b11 : 2'b00);
      ed = mapped(ea) ? ref_mem[widx(ea)] : 32'd0;
      while (!done && tries < 24) begin
        chk("rvalid_beat", 32'(rvalid), 1);
        chk("rresp", 32'(rresp), 32'(er));
        chk("rlast", 32'(rlast), 32'(b == int'(len)));
        if (er == 2'b11 || (er == 2'b00 && ref_wr[widx(ea)])) chk("rdata", rdata, ed);
        case (mode)
          0: rready = 1'b1;
          1: rready = (cyc % 2 == 0);
          2: rready = 1'($urandom_range(1, 0));
          default: rready = (cyc >= 4);
        endcase
        @(posedge clk);
        done = rready;
        cyc++; tries++;
        @(negedge clk);
      end
      chk("beat_taken", 32'(done), 1);
    end
    rready = 1'b0;
    chk("rvalid_end", 32'(rvalid), 0);
    chk("arready_end", 32'(arready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; wlast = 1; araddr = 0; arlen = 0; arsize = 2; arburst = 1;
    #12;
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, 0);
    do_read(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 0);

    do_write(BASE + 32'h14, 32'h1122_3344, 4'hF, 1'b1, 0, 0, 0);
    do_write(BASE + 32'h14, 32'h0000_AA00, 4'b0010, 1'b1, 0, 0, 0);
    chk("strobe_model", ref_mem[5], 32'h1122_AA44);
    do_read(BASE + 32'h14, 8'd0, 3'd2, 2'b01, 0);

    do_write(BASE + 32'h20, 32'hCAFE_0001, 4'hF, 1'b1, 3, 0, 4);
    do_write(BASE + 32'h24, 32'hCAFE_0002, 4'hF, 1'b1, 0, 3, 4);
    do_read(BASE + 32'h20, 8'd1, 3'd2, 2'b01, 3);

    for (int i = 0; i < 4; i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 1'b1, 0, 0, 0);
    do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 1'b1, 0, 0, 0);
    do_read(BASE, 8'd3, 3'd2, 2'b01, 1);
    do_read(BASE, 8'd2, 3'd2, 2'b00, 0);

    do_read(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 0);
    do_read(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 3'd2, 2'b01, 0);
    do_read(BASE, 8'd2, 3'd2, 2'b10, 0);
    do_read(BASE, 8'd0, 3'd3, 2'b01, 0);
    do_write(BASE + 32'(4 * DEPTH), 32'h5555_5555, 4'hF, 1'b1, 0, 0, 0);
    do_write(BASE, 32'h6666_6666, 4'hF, 1'b0, 0, 0, 0);
    do_read(BASE, 8'd0, 3'd2, 2'b01, 0);

    // Reset in the middle of beat 2 of a four-beat burst
    @(negedge clk);
    araddr = BASE; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    rready = 1'b1;
    repeat (2) @(negedge clk);
    rready = 1'b0;
    chk("pre_reset_rvalid", 32'(rvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_rlast", 32'(rlast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_arready", 32'(arready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stray_beat", 32'(rvalid), 0);
    end

    for (int i = 0; i < 16; i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 1'b1, 0, 0, 0);
    for (int i = int'(DEPTH) - 4; i < int'(DEPTH); i++)
      do_write(BASE + 32'(4 * i), $urandom, 4'hF, 1'b1, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = ($urandom_range(1, 0) == 1) ? int'($urandom_range(12, 0))
                                        : int'(DEPTH) - 1 - int'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        logic [31:0] a;
        a = BASE + 32'(4 * idx);
        if ($urandom_range(7, 0) == 0) a = BASE + 32'(4 * DEPTH) + 32'(4 * idx);
        do_write(a, $urandom, 4'($urandom_range(15, 0)), 1'($urandom_range(7, 0) != 0),
                 int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end else begin
        do_read(BASE + 32'(4 * idx), 8'($urandom_range(3, 0)), 3'd2,
                2'($urandom_range(1, 0)), 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
